// File: rtl/pipe_pkg.sv
// Pipeline stage payload types shared by the pipeline-boundary registers.
// Build option PIPE_SKID_EN (see pipe_stage_reg) does not change these types.
package pipe_pkg;

    // IF/ID datapath payload
    typedef struct packed {
        logic [63:0]  pc;
        logic [31:0]  instr;
        logic [159:0] rsvd;
    } if_id_data_t;

    // ID/EX datapath payload
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [47:0] imm;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        rsvd;
    } id_ex_data_t;

    // ID/EX control payload (WB/MEM/EX fields)
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [2:0] alu_op;
    } id_ex_ctrl_t;

    localparam int unsigned PIPE_DATA_W = $bits(id_ex_data_t);
    localparam int unsigned PIPE_CTRL_W = $bits(id_ex_ctrl_t);
    localparam int unsigned PIPE_CNT_W  = 16;

    // Control value of a bubble: no WB/MEM/EX side-effects
    localparam id_ex_ctrl_t CTRL_ZERO = '0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle of one pipeline boundary register.
// master: upstream/downstream environment side; slave: the stage register.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, stall_cnt
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// One-entry skid holding register with full flag.
// Only compiled when PIPE_SKID_EN is defined; the default build has no skid storage.
`ifdef PIPE_SKID_EN
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    input  logic [CTRL_W-1:0] push_ctrl,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic              full
);

    // Capture a payload that arrived while the main register was stalled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            full <= 1'b0;
            data <= '0;
            ctrl <= '0;
        end else if (flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
            data <= push_data;
            ctrl <= push_ctrl;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-boundary register with valid/ready handshake, flush squash,
// bubble control zeroing and a saturating stall counter.
// Define PIPE_SKID_EN to add a 1-entry skid buffer and register in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned CNT_W  = PIPE_CNT_W
) (
    input  logic            clk,
    input  logic            reset_n,
    pipe_stage_reg_if.slave bus
);

    localparam logic [CTRL_W-1:0] CTRL_CLR = CTRL_W'(CTRL_ZERO);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              take;
    logic              stall;
    logic              accept;
    logic              load;
    logic [DATA_W-1:0] src_data;
    logic [CTRL_W-1:0] src_ctrl;

    // Main register is free when empty or draining this cycle
    assign take  = !valid_q || bus.out_ready;
    assign stall = valid_q && !bus.out_ready;

`ifdef PIPE_SKID_EN
    logic              skid_full;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    // in_ready comes straight from a flop; skid contents take precedence to keep order
    assign bus.in_ready = !skid_full;
    assign accept       = bus.in_valid && !skid_full;
    assign load         = take && (skid_full || accept);
    assign src_data     = skid_full ? skid_data : bus.in_data;
    assign src_ctrl     = skid_full ? skid_ctrl : bus.in_ctrl;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.flush),
        .push      (accept && !take),
        .pop       (take && skid_full),
        .push_data (bus.in_data),
        .push_ctrl (bus.in_ctrl),
        .data      (skid_data),
        .ctrl      (skid_ctrl),
        .full      (skid_full)
    );
`else
    // No skid: ready whenever the main register can take a new payload
    assign bus.in_ready = take;
    assign accept       = bus.in_valid && take;
    assign load         = accept;
    assign src_data     = bus.in_data;
    assign src_ctrl     = bus.in_ctrl;
`endif

    // Main payload register: reset > flush > load > drain > hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_CLR;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_CLR;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= src_data;
            ctrl_q  <= src_ctrl;
        end else if (take) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_CLR;
        end
    end

    // Saturating count of cycles where a valid payload is held back
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_ctrl  = ctrl_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg (default build and PIPE_SKID_EN build).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned CW = 10;
`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [DW-1:0] PAT = {32{8'hA5}};

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) bus ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4))  bus4 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    // Reference model of the main DUT: FIFO of in-flight payloads, capacity 1 (2 with skid)
    logic [DW-1:0] q_data[$];
    logic [CW-1:0] q_ctrl[$];
    int unsigned   stall_exp;

    function automatic logic exp_ready();
        if (SKID) return q_data.size() < 2;
        return (q_data.size() == 0) || bus.out_ready;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_step();
        logic acc;
        logic emt;
        acc = bus.in_valid && exp_ready();
        emt = (q_data.size() != 0) && bus.out_ready;
        if (!reset_n) begin
            q_data.delete();
            q_ctrl.delete();
            stall_exp = 0;
        end else begin
            if ((q_data.size() != 0) && !bus.out_ready && stall_exp < 65535) stall_exp++;
            if (bus.flush) begin
                q_data.delete();
                q_ctrl.delete();
            end else begin
                if (emt) begin
                    void'(q_data.pop_front());
                    void'(q_ctrl.pop_front());
                end
                if (acc) begin
                    q_data.push_back(bus.in_data);
                    q_ctrl.push_back(bus.in_ctrl);
                end
            end
        end
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_ctrl    = '0;
        bus.flush      = 1'b0;
        bus.out_ready  = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_ctrl   = '0;
        bus4.flush     = 1'b0;
        bus4.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        advance();
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = rand_data();
        bus.in_ctrl  = 10'h3FF;
        bus4.in_valid = 1'b1;
        advance();
        advance();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_ctrl !== 10'h0) $display("FAIL reset_ctrl: got %h want 0", bus.out_ctrl); else n_pass++;
        n_checks++; if (bus.out_data !== '0) $display("FAIL reset_data: got %h want 0", bus.out_data); else n_pass++;
        n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); else n_pass++;
        n_checks++; if (bus4.out_valid !== 1'b0) $display("FAIL reset_valid4: got %b want 0", bus4.out_valid); else n_pass++;
        n_checks++; if (bus4.stall_cnt !== 4'd0) $display("FAIL reset_stall4: got %0d want 0", bus4.stall_cnt); else n_pass++;
        do_reset();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = (i < 4);
            bus.in_data   = PAT ^ DW'(i);
            bus.in_ctrl   = 10'h3FF;
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (i >= 1 && i <= 4) begin
                n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", i, bus.out_valid); else n_pass++;
                n_checks++; if (bus.out_data !== (PAT ^ DW'(i - 1))) $display("FAIL stream_data[%0d]: got %h want %h", i, bus.out_data, PAT ^ DW'(i - 1)); else n_pass++;
                n_checks++; if (bus.out_ctrl !== 10'h3FF) $display("FAIL stream_ctrl[%0d]: got %h want 3ff", i, bus.out_ctrl); else n_pass++;
            end else begin
                n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL stream_idle_valid[%0d]: got %b want 0", i, bus.out_valid); else n_pass++;
                n_checks++; if (bus.out_ctrl !== 10'h0) $display("FAIL stream_idle_ctrl[%0d]: got %h want 0", i, bus.out_ctrl); else n_pass++;
            end
            if (i == 5) begin
                n_checks++; if (bus.out_data !== (PAT ^ DW'(3))) $display("FAIL stream_hold_data: got %h want %h", bus.out_data, PAT ^ DW'(3)); else n_pass++;
            end
            n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", i, bus.in_ready); else n_pass++;
            advance();
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d1;
        logic [CW-1:0] c1;
        do_reset();
        d1 = rand_data();
        c1 = 10'h2A5;
        bus.in_valid = 1'b1; bus.in_data = d1; bus.in_ctrl = c1; bus.out_ready = 1'b1;
        advance();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d1 || bus.out_ctrl !== c1)
                $display("FAIL stall_hold[%0d]: got v=%b c=%h want v=1 c=%h", i, bus.out_valid, bus.out_ctrl, c1); else n_pass++;
            n_checks++; if (bus.in_ready !== SKID) $display("FAIL stall_ready[%0d]: got %b want %b", i, bus.in_ready, SKID); else n_pass++;
            n_checks++; if (bus.stall_cnt !== 16'(i)) $display("FAIL stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt, i); else n_pass++;
            advance();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall_cnt !== 16'd5) $display("FAIL stall_cnt_5: got %0d want 5", bus.stall_cnt); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d1) $display("FAIL stall_release: got v=%b want v=1", bus.out_valid); else n_pass++;
        advance();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'h0) $display("FAIL stall_drain: got v=%b c=%h want v=0 c=0", bus.out_valid, bus.out_ctrl); else n_pass++;
        n_checks++; if (bus.out_data !== d1) $display("FAIL stall_drain_data: got %h want %h", bus.out_data, d1); else n_pass++;
        n_checks++; if (bus.stall_cnt !== 16'd5) $display("FAIL stall_cnt_keep: got %0d want 5", bus.stall_cnt); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        bus.in_valid = 1'b1; bus.in_data = rand_data(); bus.in_ctrl = 10'h155; bus.flush = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", bus.in_ready); else n_pass++;
        advance();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'h0) $display("FAIL flush_drop[%0d]: got v=%b c=%h want v=0 c=0", i, bus.out_valid, bus.out_ctrl); else n_pass++;
            advance();
        end
        // flush while stalled: bubble inserted, counter kept
        bus.in_valid = 1'b1; bus.in_ctrl = 10'h3FF;
        advance();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        advance();
        advance();
        bus.flush = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL flush_pre_valid: got %b want 1", bus.out_valid); else n_pass++;
        advance();
        bus.flush = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 10'h0) $display("FAIL flush_stall: got v=%b c=%h want v=0 c=0", bus.out_valid, bus.out_ctrl); else n_pass++;
        n_checks++; if (bus.stall_cnt !== 16'd3) $display("FAIL flush_stall_cnt: got %0d want 3", bus.stall_cnt); else n_pass++;
        // reset beats flush
        bus.flush = 1'b1; reset_n = 1'b0;
        advance();
        bus.flush = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.stall_cnt !== 16'd0) $display("FAIL flush_reset_cnt: got %0d want 0", bus.stall_cnt); else n_pass++;
        bus.out_ready = 1'b1;
        advance();
    endtask

    task automatic test_sat();
        do_reset();
        bus4.in_valid = 1'b1; bus4.in_data = rand_data(); bus4.in_ctrl = 10'h001;
        advance();
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 14) begin
                n_checks++; if (bus4.stall_cnt !== 4'd14) $display("FAIL sat_cnt_14: got %0d want 14", bus4.stall_cnt); else n_pass++;
            end
            advance();
        end
        @(negedge clk);
        n_checks++; if (bus4.stall_cnt !== 4'd15) $display("FAIL sat_cnt_20: got %0d want 15", bus4.stall_cnt); else n_pass++;
        n_checks++; if (bus4.out_valid !== 1'b1) $display("FAIL sat_valid: got %b want 1", bus4.out_valid); else n_pass++;
        advance();
        @(negedge clk);
        n_checks++; if (bus4.stall_cnt !== 4'd15) $display("FAIL sat_hold: got %0d want 15", bus4.stall_cnt); else n_pass++;
        bus4.out_ready = 1'b1;
        advance();
    endtask

    task automatic test_random();
        logic exp_v;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.in_data   = rand_data();
            bus.in_ctrl   = CW'($urandom);
            @(negedge clk);
            exp_v = (q_data.size() != 0);
            n_checks++; if (bus.out_valid !== exp_v) $display("FAIL rand_valid[%0d]: got %b want %b", n, bus.out_valid, exp_v); else n_pass++;
            n_checks++; if (bus.out_ctrl !== (exp_v ? q_ctrl[0] : 10'h0)) $display("FAIL rand_ctrl[%0d]: got %h want %h", n, bus.out_ctrl, exp_v ? q_ctrl[0] : 10'h0); else n_pass++;
            if (exp_v) begin
                n_checks++; if (bus.out_data !== q_data[0]) $display("FAIL rand_data[%0d]: got %h want %h", n, bus.out_data, q_data[0]); else n_pass++;
            end
            n_checks++; if (bus.in_ready !== exp_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", n, bus.in_ready, exp_ready()); else n_pass++;
            n_checks++; if (bus.stall_cnt !== 16'(stall_exp)) $display("FAIL rand_stall[%0d]: got %0d want %0d", n, bus.stall_cnt, stall_exp); else n_pass++;
            advance();
        end
        set_idle();
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_skid();
        logic [DW-1:0] da;
        logic [DW-1:0] db;
        logic [DW-1:0] dc;
        do_reset();
        da = rand_data(); db = rand_data(); dc = rand_data();
        bus.in_valid = 1'b1; bus.in_data = da; bus.in_ctrl = 10'h011;
        advance();
        bus.out_ready = 1'b0; bus.in_data = db; bus.in_ctrl = 10'h022;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL skid_ready_empty: got %b want 1", bus.in_ready); else n_pass++;
        advance();
        bus.in_data = dc;
        @(negedge clk);
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL skid_ready_full: got %b want 0", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_data !== da) $display("FAIL skid_hold: got %h want %h", bus.out_data, da); else n_pass++;
        advance();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== da) $display("FAIL skid_first: got %h want %h", bus.out_data, da); else n_pass++;
        advance();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== db || bus.out_ctrl !== 10'h022) $display("FAIL skid_second: got %h want %h", bus.out_data, db); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL skid_ready_after: got %b want 1", bus.in_ready); else n_pass++;
        advance();
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL skid_empty: got %b want 0", bus.out_valid); else n_pass++;
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        stall_exp = 0;
        set_idle();
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_sat();
        test_random();
`ifdef PIPE_SKID_EN
        test_skid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
